// File: rtl/hdmi_period_tracker_pkg.sv
// Shared types and constants for the HDMI period tracker: period/state codes,
// framing-error codes and the preamble control codes.
package hdmi_period_pkg;

  typedef enum logic [2:0] {
    PER_IDLE      = 3'd0,
    PER_PREAM_T4  = 3'd1,
    PER_PREAM_VID = 3'd2,
    PER_DGB_LEAD  = 3'd3,
    PER_ISLAND    = 3'd4,
    PER_DGB_TRAIL = 3'd5,
    PER_VGB       = 3'd6,
    PER_VIDEO     = 3'd7
  } period_e;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_GB_SHORT      = 3'd1;
  localparam logic [2:0] ERR_GB_LONG       = 3'd2;
  localparam logic [2:0] ERR_PKT_TRUNC     = 3'd3;
  localparam logic [2:0] ERR_PKT_OVERFLOW  = 3'd4;
  localparam logic [2:0] ERR_VGB_IN_ISLAND = 3'd5;
  localparam logic [2:0] ERR_VID_TIMEOUT   = 3'd6;

  localparam logic [3:0] CTL_PREAM_T4  = 4'b0101;
  localparam logic [3:0] CTL_PREAM_VID = 4'b0001;

  // States whose length is policed by the shared run checker.
  function automatic logic is_run_state(input period_e s);
    return (s == PER_DGB_LEAD) || (s == PER_DGB_TRAIL) || (s == PER_VGB);
  endfunction

endpackage

// File: rtl/hdmi_period_tracker_run_checker.sv
// Run-length checker: counts a flag that must stay high for exactly LEN
// characters (the start character counts as the first).
module hdmi_run_checker #(
  parameter int LEN = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_start,
  input  logic i_en,
  input  logic i_flag,
  output logic o_done,
  output logic o_short,
  output logic o_long
);
  localparam int W = $clog2(LEN + 1);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full  = (r_cnt == W'(LEN));
  assign o_done  = i_en && !i_flag &&  w_full;
  assign o_short = i_en && !i_flag && !w_full;
  assign o_long  = i_en &&  i_flag &&  w_full;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)               r_cnt <= '0;
    else if (i_start)                 r_cnt <= W'(1);
    else if (i_en && i_flag && !w_full) r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/hdmi_period_tracker.sv
// Classifies each aligned TMDS character into an HDMI period and polices
// preamble/guardband/packet framing; all outputs registered, latency 1.
module hdmi_period_tracker
  import hdmi_period_pkg::*;
#(
  parameter int PREAMBLE_MIN = 8,
  parameter int GB_LEN       = 2,
  parameter int PKT_LEN      = 32,
  parameter int MAX_PKTS     = 18,
  parameter int ERR_CNT_W    = 16,
  parameter int VID_MAX      = 4096
) (
  input  logic                        p_clk,
  input  logic                        reset_in,
  input  logic                        valid,
  input  logic [3:0]                  ctl_code,
  input  logic [2:0]                  cv,
  input  logic [2:0]                  vgb,
  input  logic [2:0]                  dgb,
  input  logic                        clear_err,
  output logic [2:0]                  period,
  output logic                        de,
  output logic                        encoding,
  output logic                        encrypting_data,
  output logic                        encrypting_video,
  output logic                        hdcp_ena,
  output logic                        island_start,
  output logic                        pkt_strobe,
  output logic [$clog2(MAX_PKTS)-1:0] pkt_index,
  output logic                        line_end,
  output logic                        err_pulse,
  output logic [2:0]                  err_code,
  output logic [ERR_CNT_W-1:0]        err_count
);
  localparam int CW = $clog2(PKT_LEN);
  localparam int PW = $clog2(MAX_PKTS + 1);
  localparam int IW = $clog2(MAX_PKTS);
  localparam int VW = $clog2(VID_MAX + 1);

  period_e       r_state, w_nxt;
  logic [3:0]    r_pre_cnt, w_pre_cnt;
  logic          r_pre_t4, w_pre_t4, w_is_t4;
  logic [CW-1:0] r_char_cnt, w_char_cnt;
  logic [PW-1:0] r_pkt_cnt, w_pkt_cnt;
  logic [VW-1:0] r_vid_cnt, w_vid_cnt, w_vid_inc;
  logic          w_err, w_gb_start, w_isl_start, w_strobe, w_line_end;
  logic [2:0]    w_code;
  logic          w_dgb, w_vgb, w_gb_done, w_gb_short, w_gb_long;
  logic          w_unused;

  assign w_dgb     = dgb[2] & dgb[1];
  assign w_vgb     = &vgb;
  assign w_vid_inc = r_vid_cnt + VW'(1);
  assign w_unused  = dgb[0];
  assign period    = r_state;

  hdmi_run_checker #(.LEN(GB_LEN)) u_gb (
    .i_clk   (p_clk),
    .i_rst   (reset_in),
    .i_clr   (!valid),
    .i_start (w_gb_start),
    .i_en    (is_run_state(r_state)),
    .i_flag  ((r_state == PER_VGB) ? w_vgb : w_dgb),
    .o_done  (w_gb_done),
    .o_short (w_gb_short),
    .o_long  (w_gb_long)
  );

  always_comb begin
    w_nxt = r_state;  w_err = 1'b0;  w_code = ERR_NONE;
    w_gb_start = 1'b0;  w_isl_start = 1'b0;  w_strobe = 1'b0;  w_line_end = 1'b0;
    w_pre_cnt = '0;  w_pre_t4 = r_pre_t4;  w_is_t4 = 1'b0;
    w_char_cnt = r_char_cnt;  w_pkt_cnt = r_pkt_cnt;  w_vid_cnt = r_vid_cnt;
    case (r_state)
      PER_IDLE: if (&cv && (ctl_code == CTL_PREAM_T4 || ctl_code == CTL_PREAM_VID)) begin
        w_is_t4   = (ctl_code == CTL_PREAM_T4);
        w_pre_cnt = (r_pre_cnt != '0 && w_is_t4 == r_pre_t4) ? r_pre_cnt + 4'd1 : 4'd1;
        w_pre_t4  = w_is_t4;
        if (w_pre_cnt == 4'(PREAMBLE_MIN)) w_nxt = w_is_t4 ? PER_PREAM_T4 : PER_PREAM_VID;
      end
      PER_PREAM_T4: begin
        if (w_dgb) begin w_nxt = PER_DGB_LEAD; w_gb_start = 1'b1; end
        else if (&cv && ctl_code == CTL_PREAM_T4) w_nxt = PER_PREAM_T4;
        else if (w_vgb) begin w_nxt = PER_VGB; w_gb_start = 1'b1; end
        else w_nxt = PER_IDLE;
      end
      PER_PREAM_VID: begin
        if (w_vgb) begin w_nxt = PER_VGB; w_gb_start = 1'b1; end
        else if (ctl_code == CTL_PREAM_VID) w_nxt = PER_PREAM_VID;
        else w_nxt = PER_IDLE;
      end
      PER_DGB_LEAD, PER_DGB_TRAIL, PER_VGB: begin
        if (w_gb_done) begin
          if (r_state == PER_DGB_LEAD) begin
            // The character that ends the guardband is island character 0.
            w_nxt = PER_ISLAND; w_isl_start = 1'b1;
            w_char_cnt = CW'(1); w_pkt_cnt = '0;
          end else if (r_state == PER_VGB) begin
            w_nxt = PER_VIDEO; w_vid_cnt = '0;
          end else w_nxt = PER_IDLE;
        end else if (w_gb_short) begin
          w_nxt = PER_IDLE; w_err = 1'b1; w_code = ERR_GB_SHORT;
        end else if (w_gb_long) begin
          w_nxt = PER_IDLE; w_err = 1'b1; w_code = ERR_GB_LONG;
        end
      end
      PER_ISLAND: begin
        if (w_dgb) begin
          if (r_char_cnt == '0 && r_pkt_cnt != '0) begin
            w_nxt = PER_DGB_TRAIL; w_gb_start = 1'b1;
          end else begin
            w_nxt = PER_IDLE; w_err = 1'b1; w_code = ERR_PKT_TRUNC;
          end
        end else if (|cv) begin
          w_nxt = PER_IDLE; w_err = 1'b1; w_code = ERR_PKT_TRUNC;
        end else if (w_vgb) begin
          w_nxt = PER_VGB; w_gb_start = 1'b1; w_err = 1'b1; w_code = ERR_VGB_IN_ISLAND;
        end else if (r_char_cnt == '0 && r_pkt_cnt == PW'(MAX_PKTS)) begin
          w_nxt = PER_IDLE; w_err = 1'b1; w_code = ERR_PKT_OVERFLOW;
        end else if (r_char_cnt == CW'(PKT_LEN - 1)) begin
          w_strobe = 1'b1; w_char_cnt = '0; w_pkt_cnt = r_pkt_cnt + PW'(1);
        end else w_char_cnt = r_char_cnt + CW'(1);
      end
      PER_VIDEO: begin
        if (|cv) begin
          w_nxt = PER_IDLE; w_line_end = 1'b1;
        end else if (w_vid_inc == VW'(VID_MAX)) begin
          w_nxt = PER_IDLE; w_err = 1'b1; w_code = ERR_VID_TIMEOUT;
        end else w_vid_cnt = w_vid_inc;
      end
      default: w_nxt = PER_IDLE;
    endcase
    if (!valid) begin
      w_nxt = PER_IDLE;  w_err = 1'b0;  w_code = ERR_NONE;
      w_gb_start = 1'b0;  w_isl_start = 1'b0;  w_strobe = 1'b0;  w_line_end = 1'b0;
      w_pre_cnt = '0;  w_char_cnt = '0;  w_pkt_cnt = '0;  w_vid_cnt = '0;
    end
  end

  always_ff @(posedge p_clk) begin
    if (reset_in) begin
      r_state <= PER_IDLE;  r_pre_cnt <= '0;  r_pre_t4 <= 1'b0;
      r_char_cnt <= '0;  r_pkt_cnt <= '0;  r_vid_cnt <= '0;
      de <= 1'b0;  encoding <= 1'b0;  encrypting_data <= 1'b0;
      encrypting_video <= 1'b0;  hdcp_ena <= 1'b0;  island_start <= 1'b0;
      pkt_strobe <= 1'b0;  pkt_index <= '0;  line_end <= 1'b0;
      err_pulse <= 1'b0;  err_code <= ERR_NONE;  err_count <= '0;
    end else begin
      r_state <= w_nxt;  r_pre_cnt <= w_pre_cnt;  r_pre_t4 <= w_pre_t4;
      r_char_cnt <= w_char_cnt;  r_pkt_cnt <= w_pkt_cnt;  r_vid_cnt <= w_vid_cnt;
      de               <= (w_nxt == PER_VIDEO);
      encoding         <= (w_nxt == PER_ISLAND) || (w_nxt == PER_DGB_TRAIL);
      encrypting_data  <= (w_nxt == PER_ISLAND);
      encrypting_video <= (w_nxt == PER_VIDEO);
      hdcp_ena         <= (w_nxt == PER_ISLAND) || (w_nxt == PER_VIDEO);
      island_start     <= w_isl_start;
      pkt_strobe       <= w_strobe;
      if (w_strobe) pkt_index <= IW'(r_pkt_cnt);
      line_end         <= w_line_end;
      err_pulse        <= w_err;
      if (w_err) err_code <= w_code;
      if (clear_err)                  err_count <= w_err ? ERR_CNT_W'(1) : '0;
      else if (w_err && !(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
